// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared constants and types for the SRAM-backed FIFO.
// Default macro geometry, word type and active-low strobe levels.
package sram_fifo_pkg;

  localparam int WIDTH_DEF = 72;
  localparam int DEPTH_DEF = 128;

  typedef logic [WIDTH_DEF-1:0] word_t;

  localparam logic SRAM_SEL  = 1'b0;
  localparam logic SRAM_IDLE = 1'b1;

endpackage

// File: rtl/sram_fifo_outq.sv
// sram_fifo_outq: 2-entry skid queue holding words returned by the macro.
// Ports: push/push_data in, pop in, head_valid/head_data out, cnt (0..2) out.
module sram_fifo_outq
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_fire;

  assign pop_fire   = pop & head_valid;
  assign head_valid = (cnt_q != 2'd0);
  assign head_data  = e0_q;
  assign cnt        = cnt_q;

  // e0 is always the head; e1 only holds the second word.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      push && !pop_fire: begin
        if (cnt_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      !push && pop_fire: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      push && pop_fire: begin
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data;
        end else begin
          e0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller using a 1R/1W SRAM macro as storage.
// Ports: enq/deq streams, count, macro read (a1/csb1/oeb1/o1), write (a2/csb2/web2/i2).
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 3)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_data,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] sram_a1,
  output logic              sram_csb1,
  output logic              sram_oeb1,
  input  logic [WIDTH-1:0]  sram_o1,
  output logic [ADDR_W-1:0] sram_a2,
  output logic              sram_csb2,
  output logic              sram_web2,
  output logic [WIDTH-1:0]  sram_i2
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  sram_cnt_q, sram_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_inflight_q;
  logic              init_q;
  logic              enq_fire;
  logic              deq_fire;
  logic              rd_issue;
  logic [1:0]        oq_cnt;
  logic [2:0]        occ;

  // init_q holds enq_ready low until the first edge after reset.
  assign enq_ready = init_q & (sram_cnt_q != CNT_FULL);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  // Downstream slots used after this edge; deq_fire implies oq_cnt >= 1.
  assign occ = {1'b0, oq_cnt} + {2'b00, rd_inflight_q}
             - {2'b00, deq_fire};
  assign rd_issue = (sram_cnt_q != '0) & (occ < 3'd2);

  assign sram_a1   = rd_ptr_q;
  assign sram_csb1 = rd_issue ? SRAM_SEL : SRAM_IDLE;
  assign sram_oeb1 = SRAM_SEL;
  assign sram_a2   = wr_ptr_q;
  assign sram_csb2 = enq_fire ? SRAM_SEL : SRAM_IDLE;
  assign sram_web2 = enq_fire ? SRAM_SEL : SRAM_IDLE;
  assign sram_i2   = enq_data;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (enq_fire)
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0
               : wr_ptr_q + ADDR_W'(1);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (rd_issue)
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0
               : rd_ptr_q + ADDR_W'(1);
  end

  always_comb begin
    sram_cnt_d = sram_cnt_q;
    unique case ({enq_fire, rd_issue})
      2'b10:   sram_cnt_d = sram_cnt_q + CNT_W'(1);
      2'b01:   sram_cnt_d = sram_cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Total held changes only at the stream boundaries.
  always_comb begin
    count_d = count_q;
    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      count_q       <= '0;
      rd_inflight_q <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sram_cnt_q    <= sram_cnt_d;
      count_q       <= count_d;
      rd_inflight_q <= rd_issue;
      init_q        <= 1'b1;
    end
  end

  sram_fifo_outq #(
    .WIDTH(WIDTH)
  ) u_outq (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_inflight_q),
    .push_data (sram_o1),
    .pop       (deq_ready),
    .head_valid(deq_valid),
    .head_data (deq_data),
    .cnt       (oq_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed bench with a per-cycle occupancy model
// and a behavioural 128x72 two-port macro beside the controller.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  localparam int W  = 72;
  localparam int D  = 128;
  localparam int AW = 7;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enq_valid = 1'b0;
  logic          enq_ready;
  logic [W-1:0]  enq_data = '0;
  logic          deq_valid;
  logic          deq_ready = 1'b0;
  logic [W-1:0]  deq_data;
  logic [CW-1:0] count;
  logic [AW-1:0] sram_a1;
  logic          sram_csb1;
  logic          sram_oeb1;
  logic [W-1:0]  sram_o1;
  logic [AW-1:0] sram_a2;
  logic          sram_csb2;
  logic          sram_web2;
  logic [W-1:0]  sram_i2;

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .enq_data (enq_data),
    .deq_valid(deq_valid),
    .deq_ready(deq_ready),
    .deq_data (deq_data),
    .count    (count),
    .sram_a1  (sram_a1),
    .sram_csb1(sram_csb1),
    .sram_oeb1(sram_oeb1),
    .sram_o1  (sram_o1),
    .sram_a2  (sram_a2),
    .sram_csb2(sram_csb2),
    .sram_web2(sram_web2),
    .sram_i2  (sram_i2)
  );

  word_t mem [D];

  always @(posedge clk) begin
    if (!sram_csb2 && !sram_web2) mem[sram_a2] <= sram_i2;
    if (!sram_csb1) sram_o1 <= mem[sram_a1];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: the FIFO contents as a queue, plus how many words have been
  // written to / read from the macro. From those, the split between
  // macro, in-flight read and output queue follows directly.
  word_t q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int started = 0;
  int prev_iss = 0;

  always @(negedge clk) begin : cmp
    int   in_mac, down, outq;
    logic e_dv, e_rdy, e_df, e_iss, e_ef;
    if (reset) begin
      chk("rst_deq_valid", deq_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_csb1", sram_csb1, 1);
      chk("rst_csb2", sram_csb2, 1);
      chk("rst_web2", sram_web2, 1);
      chk("rst_enq_ready", enq_ready, 0);
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
      started = 0;
      prev_iss = 0;
    end else begin
      in_mac = wr_cnt - rd_cnt;
      down   = q.size() - in_mac;
      outq   = down - prev_iss;
      e_dv   = (outq > 0);
      e_rdy  = (started != 0) && (in_mac != D);
      e_df   = e_dv && deq_ready;
      e_iss  = (in_mac != 0) && ((down - int'(e_df)) < 2);
      e_ef   = enq_valid && e_rdy;
      chk("deq_valid", deq_valid, e_dv);
      chk("enq_ready", enq_ready, e_rdy);
      chk("count", count, q.size());
      chk("csb1", sram_csb1, !e_iss);
      chk("csb2", sram_csb2, !e_ef);
      chk("web2", sram_web2, !e_ef);
      chk("oeb1", sram_oeb1, 0);
      if (e_iss) chk("a1", sram_a1, rd_cnt % D);
      if (e_ef) begin
        chk("a2", sram_a2, wr_cnt % D);
        chk("i2", sram_i2, enq_data);
      end
      if (e_dv && q.size() > 0) chk("deq_data", deq_data, q[0]);
      if (!sram_csb1 && !sram_csb2)
        chk("addr_clash", sram_a1 == sram_a2, 0);
      if (e_ef) begin
        q.push_back(enq_data);
        wr_cnt++;
      end
      if (e_df && q.size() > 0) void'(q.pop_front());
      if (e_iss) rd_cnt++;
      prev_iss = int'(e_iss);
      started = 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  word_t sb[$];
  int acc, got, sent, errs, fe, fd, bub, cerr, rises;
  int last1, last2, w1, w2;
  logic prev_rdy, prev_iss_obs, seen;

  initial begin
    // 1: single word
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    obs();
    chk("rdy_hold", enq_ready, 0);
    nxt();
    obs();
    chk("rdy_rise", enq_ready, 1);
    nxt();
    enq_valid = 1'b1;
    enq_data  = 72'hA5;
    deq_ready = 1'b1;
    obs();
    chk("t1_csb2", sram_csb2, 0);
    chk("t1_web2", sram_web2, 0);
    chk("t1_a2", sram_a2, 0);
    nxt();
    enq_valid = 1'b0;
    obs();
    chk("t1_csb1", sram_csb1, 0);
    chk("t1_a1", sram_a1, 0);
    chk("t1_count", count, 1);
    nxt();
    obs();
    chk("t1_dv_c2", deq_valid, 0);
    nxt();
    obs();
    chk("t1_dv_c3", deq_valid, 1);
    chk("t1_data", deq_data, 72'hA5);
    nxt();
    obs();
    chk("t1_dv_c4", deq_valid, 0);
    chk("t1_cnt_c4", count, 0);

    // 2: fill to capacity, then drain
    acc = 0;
    for (int c = 0; c < 140; c++) begin
      nxt();
      enq_valid = 1'b1;
      deq_ready = 1'b0;
      enq_data  = W'(acc);
      obs();
      if (enq_ready) acc++;
    end
    chk("t2_accepted", acc, 130);
    chk("t2_rdy_full", enq_ready, 0);
    chk("t2_count", count, 130);
    got = 0;
    errs = 0;
    for (int c = 0; c < 400 && got < 130; c++) begin
      nxt();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      obs();
      if (deq_valid) begin
        if (deq_data != W'(got)) errs++;
        got++;
      end
    end
    chk("t2_drained", got, 130);
    chk("t2_order", errs, 0);

    // 3: streaming
    sent = 0; got = 0; fe = -1; fd = -1;
    bub = 0; cerr = 0; errs = 0;
    for (int c = 0; c < 1200 && got < 1000; c++) begin
      nxt();
      enq_valid = (sent < 1000);
      deq_ready = 1'b1;
      enq_data  = W'(1000 + sent);
      obs();
      if (enq_valid && !enq_ready) cerr++;
      if (enq_valid && enq_ready) begin
        if (fe < 0) fe = c;
        if (c - fe >= 3 && count != 8'd3) cerr++;
        sent++;
      end
      if (deq_valid) begin
        if (fd < 0) fd = c;
        if (deq_data != W'(1000 + got)) errs++;
        got++;
      end else if (got > 0 && got < 1000) begin
        bub++;
      end
    end
    chk("t3_latency", fd - fe, 3);
    chk("t3_bubbles", bub, 0);
    chk("t3_order", errs, 0);
    chk("t3_count3", cerr, 0);
    chk("t3_got", got, 1000);

    // 4: random valid/ready, address wrap
    sent = 0; got = 0; errs = 0;
    last1 = -1; last2 = -1; w1 = 0; w2 = 0;
    sb.delete();
    for (int c = 0; c < 4000 && got < 400; c++) begin
      nxt();
      enq_valid = (sent < 400) && ($urandom_range(0, 1) == 1);
      deq_ready = ($urandom_range(0, 1) == 1);
      enq_data  = {$urandom, $urandom, 8'($urandom)};
      obs();
      if (enq_valid && enq_ready) begin
        sb.push_back(enq_data);
        sent++;
        if (last2 == 127 && sram_a2 == 7'd0) w2 = 1;
        last2 = int'(sram_a2);
      end
      if (!sram_csb1) begin
        if (last1 == 127 && sram_a1 == 7'd0) w1 = 1;
        last1 = int'(sram_a1);
      end
      if (deq_valid && deq_ready) begin
        if (sb.size() == 0) errs++;
        else if (deq_data != sb.pop_front()) errs++;
        got++;
      end
    end
    chk("t4_got", got, 400);
    chk("t4_order", errs, 0);
    chk("t4_wrap_a1", w1, 1);
    chk("t4_wrap_a2", w2, 1);

    // 5: full with toggling deq_ready
    acc = 0;
    for (int c = 0; c < 140; c++) begin
      nxt();
      enq_valid = 1'b1;
      deq_ready = 1'b0;
      enq_data  = W'(5000 + acc);
      obs();
      if (enq_ready) acc++;
    end
    chk("t5_full", count, 130);
    sent = acc; got = 0; errs = 0; rises = 0;
    prev_rdy = enq_ready;
    prev_iss_obs = !sram_csb1;
    for (int c = 0; c < 60; c++) begin
      nxt();
      enq_valid = 1'b1;
      deq_ready = ((c % 2) == 0);
      enq_data  = W'(5000 + sent);
      obs();
      if (enq_ready && !prev_rdy) begin
        rises++;
        chk("t5_rdy_after_issue", prev_iss_obs, 1);
      end
      prev_rdy = enq_ready;
      prev_iss_obs = !sram_csb1;
      if (enq_ready) sent++;
      if (deq_valid && deq_ready) begin
        if (deq_data != W'(5000 + got)) errs++;
        got++;
      end
    end
    chk("t5_rises", rises > 0, 1);
    for (int c = 0; c < 400 && got < sent; c++) begin
      nxt();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      obs();
      if (deq_valid) begin
        if (deq_data != W'(5000 + got)) errs++;
        got++;
      end
    end
    chk("t5_all_out", got, sent);
    chk("t5_order", errs, 0);

    // 6: reset with a read in flight
    nxt();
    enq_valid = 1'b1;
    deq_ready = 1'b0;
    enq_data  = W'(77);
    obs();
    nxt();
    enq_data = W'(78);
    obs();
    nxt();
    enq_data = W'(79);
    obs();
    nxt();
    enq_valid = 1'b0;
    obs();
    chk("t6_pre_count", count, 3);
    chk("t6_pre_dv", deq_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_dv", deq_valid, 0);
    chk("t6_rst_count", count, 0);
    nxt();
    nxt();
    reset = 1'b0;
    obs();
    nxt();
    enq_valid = 1'b1;
    enq_data  = W'(1);
    deq_ready = 1'b1;
    obs();
    chk("t6_enq", sram_csb2, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      nxt();
      enq_valid = 1'b0;
      obs();
      if (deq_valid) begin
        seen = 1'b1;
        chk("t6_data", deq_data, 72'h1);
      end
    end
    chk("t6_seen", seen, 1);
    nxt();
    obs();
    chk("t6_empty", deq_valid, 0);

    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
